io_handshake_responder: RTL and testbench

- Device-side responder for the processor's IO request handshake.
- Control raises is_input or is_output and stalls. This block serves the request:
  - Input: captures switches on an operator confirmation press.
  - Output: latches MemOut for display and waits for a continue press.
- Completion is acknowledged with io_done, which stays high until Control drops the request.
- Sits between the debounced buttons/switches and Control/IOmodule, in the fast_clock domain.

---
 rtl/io_handshake_responder_if.sv | 41 ++++
 rtl/io_handshake_responder.sv | 182 ++++++++++++++++++
 tb/tb_io_handshake_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_handshake_responder_if.sv
// Handshake bundle between Control/IOmodule and the IO responder.
//   master : the request side (Control, buttons, switches, MemOut)
//   slave  : the responder (io_handshake_responder)
// Signals:
//   is_input / is_output : level requests from Control
//   sw                   : switch bank, MSB is the sign switch
//   confirmation         : debounced confirm button (active-high level)
//   continue_btn         : debounced continue button (active-high level);
//                          "continue" is a reserved word, hence the suffix
//   MemOut               : word to show on output requests
//   IData                : captured input word to the load path
//   display_value        : latched output word for the display
//   io_done              : request served (held until the request drops)
//   busy                 : responder is waiting or acknowledging
//   timed_out            : last request ended by timeout (sticky)
interface io_handshake_responder_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IO_WIDTH   = 16
);
  logic                  is_input;
  logic                  is_output;
  logic [IO_WIDTH:0]     sw;
  logic                  confirmation;
  logic                  continue_btn;
  logic [DATA_WIDTH-1:0] MemOut;
  logic [DATA_WIDTH-1:0] IData;
  logic [DATA_WIDTH-1:0] display_value;
  logic                  io_done;
  logic                  busy;
  logic                  timed_out;

  modport master (
    output is_input, is_output, sw, confirmation, continue_btn, MemOut,
    input  IData, display_value, io_done, busy, timed_out
  );

  modport slave (
    input  is_input, is_output, sw, confirmation, continue_btn, MemOut,
    output IData, display_value, io_done, busy, timed_out
  );
endinterface

// File: rtl/io_handshake_responder.sv
// Device-side responder for the processor's IO request handshake.
// Control raises is_input or is_output and stalls; this block serves it:
//   input  : waits for a fresh confirmation press, captures the switches
//            (sign-extended) into IData
//   output : latches MemOut into display_value, waits for a fresh continue
//            press
// Completion is signalled with io_done, held until Control drops the request.
//
// Ports:
//   fast_clock : sole clock, rising edge
//   reset      : asynchronous, active-low
//   bus        : io_handshake_responder_if.slave (requests, buttons,
//                switches, MemOut in; IData, display_value, io_done, busy,
//                timed_out out)
//
// Optional feature, macro IO_TIMEOUT_EN: a wait that sees no button edge for
// TIMEOUT_CYCLES cycles is completed anyway (IData cleared on input waits)
// and timed_out is set. Without the macro waits are unbounded and timed_out
// is tied low.
module io_handshake_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int IO_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                   fast_clock,
  input  logic                   reset,
  io_handshake_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IN  = 2'd1,
    WAIT_OUT = 2'd2,
    ACK      = 2'd3
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] idata_q;
  logic [DATA_WIDTH-1:0] disp_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  conf_q;
  logic                  cont_q;

  logic                  conf_rise;
  logic                  cont_rise;
  logic                  rd_req;
  logic                  wr_req;
  logic                  any_req;
  logic [DATA_WIDTH-1:0] sw_ext;

  // A button already held when a wait starts must not complete it, so only
  // rising edges count.
  assign conf_rise = bus.confirmation & ~conf_q;
  assign cont_rise = bus.continue_btn & ~cont_q;

  // Conflicting requests (both high) decode as no request.
  assign rd_req  = bus.is_input  & ~bus.is_output;
  assign wr_req  = bus.is_output & ~bus.is_input;
  assign any_req = bus.is_input  |  bus.is_output;

  // The sign switch fills every bit above the switch bank.
  assign sw_ext = {{(DATA_WIDTH-IO_WIDTH-1){bus.sw[IO_WIDTH]}}, bus.sw};

`ifdef IO_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] wait_cnt_q;
  logic        tmo_q;
`else
  // The timeout length only matters when the timeout logic is built in.
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

  always_ff @(posedge fast_clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      idata_q    <= '0;
      disp_q     <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      conf_q     <= 1'b0;
      cont_q     <= 1'b0;
`ifdef IO_TIMEOUT_EN
      wait_cnt_q <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      conf_q <= bus.confirmation;
      cont_q <= bus.continue_btn;

      unique case (state_q)
        IDLE: begin
          if (rd_req) begin
            state_q    <= WAIT_IN;
            busy_q     <= 1'b1;
`ifdef IO_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end else if (wr_req) begin
            // Display word is taken on the accepting edge itself.
            disp_q     <= bus.MemOut;
            state_q    <= WAIT_OUT;
            busy_q     <= 1'b1;
`ifdef IO_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end
        end

        WAIT_IN: begin
          if (!rd_req) begin
            // Request withdrawn: leave without touching IData or io_done.
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (conf_rise) begin
            idata_q <= sw_ext;
            state_q <= ACK;
            done_q  <= 1'b1;
`ifdef IO_TIMEOUT_EN
            tmo_q   <= 1'b0;
          end else if (wait_cnt_q == TMO_LAST) begin
            idata_q <= '0;
            state_q <= ACK;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
`endif
          end
        end

        WAIT_OUT: begin
          if (!wr_req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cont_rise) begin
            state_q <= ACK;
            done_q  <= 1'b1;
`ifdef IO_TIMEOUT_EN
            tmo_q   <= 1'b0;
          end else if (wait_cnt_q == TMO_LAST) begin
            state_q <= ACK;
            done_q  <= 1'b1;
            tmo_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
`endif
          end
        end

        ACK: begin
          // Hold the acknowledge until Control has dropped both requests,
          // so a request that changes type here is not served twice.
          if (!any_req) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IData         = idata_q;
  assign bus.display_value = disp_q;
  assign bus.io_done       = done_q;
  assign bus.busy          = busy_q;
`ifdef IO_TIMEOUT_EN
  assign bus.timed_out     = tmo_q;
`else
  assign bus.timed_out     = 1'b0;
`endif

endmodule

// File: tb/tb_io_handshake_responder.sv
module tb_io_handshake_responder;

  localparam int DW  = 32;
  localparam int IW  = 16;
  localparam int TMO = 8;

  logic fast_clock = 1'b0;
  logic reset      = 1'b1;

  io_handshake_responder_if #(.DATA_WIDTH(DW), .IO_WIDTH(IW)) bus ();

  io_handshake_responder #(
    .DATA_WIDTH    (DW),
    .IO_WIDTH      (IW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .fast_clock(fast_clock),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 fast_clock = ~fast_clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // What the operator sees: which request is being served (none / read /
  // write), whether it has been answered, and the words shown so far.
  int              m_serving  = 0;   // 0 none, 1 read, 2 write
  bit              m_answered = 0;
  int              m_waited   = 0;
  logic [DW-1:0]   m_idata    = '0;
  logic [DW-1:0]   m_disp     = '0;
  bit              m_to       = 0;
  bit              m_conf_prev = 0;
  bit              m_cont_prev = 0;

  always @(posedge fast_clock or negedge reset) begin
    if (!reset) begin
      m_serving = 0; m_answered = 0; m_waited = 0;
      m_idata = '0; m_disp = '0; m_to = 0;
      m_conf_prev = 0; m_cont_prev = 0;
    end else begin
      int  req;
      bit  press;
      req = (bus.is_input && !bus.is_output) ? 1 :
            (bus.is_output && !bus.is_input) ? 2 : 0;
      press = (m_serving == 1) ? (bus.confirmation && !m_conf_prev)
                               : (bus.continue_btn && !m_cont_prev);
      if (m_answered) begin
        if (!bus.is_input && !bus.is_output) begin
          m_answered = 0; m_serving = 0;
        end
      end else if (m_serving == 0) begin
        if (req != 0) begin
          m_serving = req; m_waited = 0;
          if (req == 2) m_disp = bus.MemOut;
        end
      end else if (req != m_serving) begin
        m_serving = 0;
      end else if (press) begin
        if (m_serving == 1) m_idata = DW'($signed(bus.sw));
        m_answered = 1; m_to = 0;
      end else begin
        m_waited++;
`ifdef IO_TIMEOUT_EN
        if (m_waited == TMO) begin
          if (m_serving == 1) m_idata = '0;
          m_answered = 1; m_to = 1;
        end
`endif
      end
      m_conf_prev = bus.confirmation;
      m_cont_prev = bus.continue_btn;
    end
  end

  // One compare process, every cycle, away from the active edge.
  always @(negedge fast_clock) begin
    chk("mon_IData",   bus.IData,         m_idata);
    chk("mon_display", bus.display_value, m_disp);
    chk("mon_io_done", DW'(bus.io_done),  DW'(m_answered));
    chk("mon_busy",    DW'(bus.busy),     DW'(m_serving != 0));
    chk("mon_timeout", DW'(bus.timed_out), DW'(m_to));
  end

  task automatic step(input int n);
    repeat (n) @(posedge fast_clock);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.is_input = 0; bus.is_output = 0; bus.sw = '0;
    bus.confirmation = 0; bus.continue_btn = 0; bus.MemOut = '0;
    #2 reset = 0;
    step(2);
    chk("rst_busy",    DW'(bus.busy),    '0);
    chk("rst_io_done", DW'(bus.io_done), '0);
    chk("rst_IData",   bus.IData,        '0);
    reset = 1;
    step(1);

    // Input path with negative sign switch
    bus.sw = 17'h1_8001; bus.is_input = 1;
    step(1);
    chk("in_busy", DW'(bus.busy), 32'd1);
    bus.confirmation = 1;
    step(1);
    chk("in_done",  DW'(bus.io_done), 32'd1);
    chk("in_IData", bus.IData, 32'hFFFF8001);
    bus.confirmation = 0;
    step(1);
    bus.is_input = 0;
    step(1);
    chk("in_drop_done", DW'(bus.io_done), 32'd0);
    step(1);

    // Held confirmation does not complete; fresh press does
    bus.confirmation = 1;
    step(2);
    bus.sw = 17'h0_00A5; bus.is_input = 1;
    step(4);
    chk("held_done", DW'(bus.io_done), 32'd0);
    chk("held_busy", DW'(bus.busy),    32'd1);
    bus.confirmation = 0;
    step(1);
    bus.confirmation = 1;
    step(1);
    chk("held_IData", bus.IData, 32'h000000A5);
    chk("held_done2", DW'(bus.io_done), 32'd1);
    bus.confirmation = 0; bus.is_input = 0;
    step(2);

    // Output path
    bus.MemOut = 32'hDEADBEEF; bus.is_output = 1;
    step(1);
    chk("out_disp", bus.display_value, 32'hDEADBEEF);
    chk("out_busy", DW'(bus.busy), 32'd1);
    bus.MemOut = 32'h12345678;
    step(2);
    bus.continue_btn = 1;
    step(1);
    chk("out_done", DW'(bus.io_done), 32'd1);
    bus.continue_btn = 0; bus.is_output = 0;
    step(2);
    chk("out_disp_held", bus.display_value, 32'hDEADBEEF);
    chk("out_idle_busy", DW'(bus.busy), 32'd0);

    // Conflicting requests stay idle
    bus.is_input = 1; bus.is_output = 1;
    step(3);
    chk("both_busy", DW'(bus.busy), 32'd0);
    bus.is_input = 0; bus.is_output = 0;
    step(1);

    // Abort during input wait
    bus.sw = 17'h1_FFFF; bus.is_input = 1;
    step(1);
    chk("abort_busy1", DW'(bus.busy), 32'd1);
    bus.is_input = 0;
    step(1);
    chk("abort_busy0", DW'(bus.busy), 32'd0);
    chk("abort_IData", bus.IData, 32'h000000A5);
    step(1);

    // Asynchronous reset in the middle of an input wait
    bus.is_input = 1;
    step(2);
    #2 reset = 0;
    #1;
    chk("arst_busy", DW'(bus.busy), 32'd0);
    chk("arst_IData", bus.IData, 32'd0);
    chk("arst_disp", bus.display_value, 32'd0);
    bus.is_input = 0;
    step(1);
    reset = 1;
    step(1);

    // Another positive input word
    bus.sw = 17'h0_1234; bus.is_input = 1;
    step(1);
    bus.confirmation = 1;
    step(1);
    chk("in2_IData", bus.IData, 32'h00001234);
    bus.confirmation = 0; bus.is_input = 0;
    step(2);

`ifdef IO_TIMEOUT_EN
    // Input wait with no press times out after TMO waiting cycles
    bus.is_input = 1;
    step(1);
    step(TMO - 1);
    chk("tmo_early", DW'(bus.io_done), 32'd0);
    step(1);
    chk("tmo_done",  DW'(bus.io_done), 32'd1);
    chk("tmo_IData", bus.IData, 32'd0);
    chk("tmo_flag",  DW'(bus.timed_out), 32'd1);
    bus.is_input = 0;
    step(2);
    bus.is_input = 1;
    step(1);
    bus.confirmation = 1;
    step(1);
    chk("tmo_clear", DW'(bus.timed_out), 32'd0);
    bus.confirmation = 0; bus.is_input = 0;
    step(2);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
